// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and types for the seven-segment scan controller.
package ssd_pkg;
    localparam int DEF_DIGITS = 4;
    localparam int DEF_DIV = 50000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    typedef enum logic {IDLE, PEND} state_t;
endpackage

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: 4-bit nibble to active-low {g..a} hex glyph.
module hex_seg_decoder (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment scanner with frame-aligned load handshake.
// Define SSD_LZ_BLANK_EN to additionally blank leading-zero digits.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int DIV = DEF_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    output logic                  ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an_out
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx, idx_nxt;
    logic tick, wrap, xfer;
    state_t state, state_nxt;
    logic [4*DIGITS-1:0] pend_val, disp_val, show_val;
    logic [DIGITS-1:0] pend_mask, disp_mask, show_mask, dark;
    logic [3:0] nib;
    logic [6:0] glyph;

    assign tick = cnt == CW'(DIV - 1);
    assign wrap = tick && idx == IW'(DIGITS - 1);
    assign xfer = wrap && state == PEND;
    assign idx_nxt = tick ? (wrap ? '0 : idx + 1'b1) : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            idx <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb state_nxt = state == IDLE ? (load ? PEND : IDLE) : (wrap ? IDLE : PEND);

    always_comb ready = state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_mask <= '0;
            disp_val <= '0;
            disp_mask <= '0;
        end else begin
            if (state == IDLE && load) begin
                pend_val <= value;
                pend_mask <= blank_mask;
            end
            if (xfer) begin
                disp_val <= pend_val;
                disp_mask <= pend_mask;
            end
        end
    end

    // Bypass the copy so the new frame's digit 0 already shows the new content.
    assign show_val = xfer ? pend_val : disp_val;
    assign show_mask = xfer ? pend_mask : disp_mask;

`ifdef SSD_LZ_BLANK_EN
    logic [DIGITS-1:0] lz;
    logic seen;
    always_comb begin
        lz = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen = seen | (show_val[4*i +: 4] != 4'h0);
            lz[i] = !seen;
        end
    end
    assign dark = show_mask | lz;
`else
    assign dark = show_mask;
`endif

    assign nib = show_val[{idx_nxt, 2'b00} +: 4];

    hex_seg_decoder u_dec (
        .nib(nib),
        .seg(glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= SEG_OFF;
            an_out <= '1;
        end else begin
            seg_out <= dark[idx_nxt] ? SEG_OFF : glyph;
            an_out <= dark[idx_nxt] ? '1 : ~(DIGITS'(1) << idx_nxt);
        end
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl with DIV=4, DIGITS=4.
module tb_ssd_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 0;
    logic rst_n = 1;
    logic load = 0;
    logic ready;
    logic [15:0] value = '0;
    logic [3:0] blank_mask = '0;
    logic [6:0] seg_out;
    logic [3:0] an_out;

    int ncyc;
    int n_vec = 0;
    int n_err = 0;
    int s = 0;
    logic [10:0] exp_q [$];

    ssd_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .ready(ready),
        .value(value),
        .blank_mask(blank_mask),
        .seg_out(seg_out),
        .an_out(an_out)
    );

    always #5 clk = ~clk;

    // Edge count since reset release; slot s is sampled after edge 4*s+1.
    always @(posedge clk or negedge rst_n) ncyc <= !rst_n ? 0 : ncyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lz_of(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
`ifdef SSD_LZ_BLANK_EN
        for (int k = 1; k < 4; k++) r[k] = (v >> (4 * k)) == 16'h0;
`endif
        return r;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] m);
        logic [3:0] lz;
        logic blank;
        lz = lz_of(v);
        for (int k = 0; k < 4; k++) begin
            blank = m[k] | lz[k];
            exp_q.push_back({blank ? 4'hF : 4'(~(4'b0001 << k)), blank ? 7'h7F : GLYPH[v[4*k +: 4]]});
        end
    endtask

    task automatic slot_check();
        int g;
        logic [10:0] e;
        g = 0;
        while (ncyc != 4 * s + 1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("slot_wait", 16'(ncyc), 16'(4 * s + 1));
        if (exp_q.size() == 0) begin
            check("sb_empty", 16'(exp_q.size()), 16'd1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("slot%0d_an", s), {12'h0, an_out}, {12'h0, e[10:7]});
            check($sformatf("slot%0d_seg", s), {9'h0, seg_out}, {9'h0, e[6:0]});
        end
        s++;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        value = v;
        blank_mask = m;
        load = 1;
        @(posedge clk);
        #1;
        load = 0;
        value = 16'($urandom);
        blank_mask = 4'($urandom);
    endtask

    initial begin
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst_seg", {9'h0, seg_out}, 16'h007F);
        check("rst_an", {12'h0, an_out}, 16'h000F);
        check("rst_ready", {15'h0, ready}, 16'h0001);
        rst_n = 1;
        s = 0;
        push_frame(16'h0000, 4'b0000);
        slot_check();
        do_load(16'h12AF, 4'b0000);
        check("pend_ready", {15'h0, ready}, 16'h0000);
        slot_check();
        do_load(16'h0000, 4'b0000);
        repeat (2) slot_check();
        push_frame(16'h12AF, 4'b0000);
        slot_check();
        check("f1_ready", {15'h0, ready}, 16'h0001);
        do_load(16'h8888, 4'b0100);
        repeat (3) slot_check();
        push_frame(16'h8888, 4'b0100);
        repeat (4) slot_check();
        repeat (2) @(negedge clk);
        value = 16'h3C5D;
        blank_mask = 4'b0000;
        load = 1;
        @(posedge clk);
        #1;
        load = 0;
        value = 16'($urandom);
        blank_mask = 4'($urandom);
        push_frame(16'h8888, 4'b0100);
        slot_check();
        check("tick_load_ready", {15'h0, ready}, 16'h0000);
        repeat (3) slot_check();
        push_frame(16'h3C5D, 4'b0000);
        slot_check();
        check("f4_ready", {15'h0, ready}, 16'h0001);
        do_load(16'h0005, 4'b0000);
        repeat (3) slot_check();
        push_frame(16'h0005, 4'b0000);
        slot_check();
        do_load(16'h0000, 4'b0000);
        repeat (3) slot_check();
        push_frame(16'h0000, 4'b0000);
        slot_check();
        do_load(16'hABCD, 4'b0000);
        check("f6_pend", {15'h0, ready}, 16'h0000);
        slot_check();
        rst_n = 0;
        #1;
        check("mid_rst_seg", {9'h0, seg_out}, 16'h007F);
        check("mid_rst_an", {12'h0, an_out}, 16'h000F);
        check("mid_rst_ready", {15'h0, ready}, 16'h0001);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        s = 0;
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        repeat (8) slot_check();
        check("post_rst_ready", {15'h0, ready}, 16'h0001);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter DIV, default 50000, clk cycles per digit slot (>=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  request to latch new value/blank_mask; accepted only when ready=1.
REQ-006 ready  output  1  high = controller can accept load.
REQ-007 value  input  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = LSN).
REQ-008 blank_mask  input  DIGITS  bit i set = digit i forced dark.
REQ-009 seg_out  output  7  segment drive {g..a}, active-low, registered.
REQ-010 an_out  output  DIGITS  digit enables, active-low, one-hot-low or all-high, registered.

Function
REQ-011 Prescaler SHALL count 0..DIV-1 and wrap; tick is asserted on the cycle count==DIV-1.
REQ-012 Digit index SHALL advance on tick, wrapping DIGITS-1 -> 0; wrap marks frame start.
REQ-013 seg_out/an_out SHALL reflect the new digit index one cycle after tick (latency 1).
REQ-014 Handshake FSM SHALL have states IDLE (ready=1) and PEND (ready=0).
REQ-015 IDLE + load=1 -> capture value/blank_mask into pending register, go to PEND next cycle.
REQ-016 PEND: load ignored; on tick with index wrapping to 0, pending copies to display register and FSM returns to IDLE; ready rises the cycle after the copy.
REQ-017 Updated content SHALL first appear on digit 0 of the same frame-start slot (no torn frame).
REQ-018 Active digit i not blanked: an_out[i]=0, others 1, seg_out = glyph of nibble i (0-F, standard hex glyphs, e.g. 0=1000000, A=0001000, F=0001110).
REQ-019 Active digit i blanked: an_out all 1, seg_out=1111111.
REQ-020 Load asserted on the same cycle as a frame-start tick in IDLE: capture occurs, transfer waits for the next frame start.
REQ-021 Display register content SHALL be unchanged between transfers regardless of value/blank_mask inputs.

Reset
REQ-022 rst_n=0 SHALL immediately force: seg_out=1111111, an_out all 1, ready=1, FSM=IDLE.
REQ-023 Reset SHALL clear prescaler, digit index, pending and display registers to 0, blank masks to 0.
REQ-024 Reset mid-PEND SHALL discard pending data; first post-reset tick shows digit 0 with value 0.

Configuration
REQ-025 Macro SSD_LZ_BLANK_EN defined: leading-zero suppression -- digits above the highest nonzero nibble are additionally blanked; digit 0 always lit unless masked.
REQ-026 Macro undefined: no suppression; only blank_mask darkens digits.

Structure
REQ-027 Package ssd_pkg SHALL hold SEG_OFF (1111111) constant, FSM state typedef, default DIGITS/DIV.
REQ-028 Sub-module hex_seg_decoder (combinational 4-bit -> 7-bit active-low glyph) SHALL be instantiated once, shared across digits by the scan mux.

Verification (DIV=4, DIGITS=4)
REQ-029 Reset release, no load -> an_out cycles 1110,1101,1011,0111 every 4 clk; seg_out=1000000 each slot.
REQ-030 load with value=16'h12AF, mask=0 -> ready low until next frame start; then digit0=0001110, digit1=0001000, digit2=0100100, digit3=1111001.
REQ-031 Second load while ready=0 with 16'h0000 -> ignored; 16'h12AF displayed.
REQ-032 mask=4'b0100, value=16'h8888 -> slot 2 shows an_out=1111, seg_out=1111111; others 0000000.
REQ-033 rst_n low mid-PEND -> outputs dark same cycle; after release value 0 shown, ready=1.
REQ-034 SSD_LZ_BLANK_EN, value=16'h0005 -> digits 3..1 dark, digit0=0010010; value=16'h0000 -> digit0=1000000 only.
